// File: rtl/prio_pkg.sv
// Shared constants, FSM state type and index helpers for the priority
// encoder / decoder-collector pair.
package prio_pkg;
    localparam int IDX_W = 3;
    localparam int VEC_W = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic logic [VEC_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [VEC_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Highest set index, i.e. what the upstream priority encoder reports.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [VEC_W-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < VEC_W; i++)
            if (vec[i]) idx = IDX_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/popcount_vec.sv
// Combinational population count of a VEC_W-bit vector.
module popcount_vec #(
    parameter int VEC_W = 8,
    parameter int OUT_W = 4
) (
    input  logic [VEC_W-1:0] vec,
    output logic [OUT_W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < VEC_W; i++)
            cnt = cnt + {{(OUT_W-1){1'b0}}, vec[i]};
    end
endmodule

// File: rtl/prio_dec_collect.sv
// Rebuilds a request vector from a framed stream of indices; emits the
// registered vector with its popcount and a repeated-index flag.
module prio_dec_collect
    import prio_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [VEC_W-1:0]     out_vec,
    output logic [IDX_W:0]       out_cnt,
    output logic                 out_dup,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     frames_done
);
    state_t           state, state_nx;
    logic [VEC_W-1:0] acc, beat_oh, merged;
    logic             dup, beat_dup, accept;
    logic [IDX_W:0]   merged_cnt;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign beat_oh  = onehot(in_idx);
    assign merged   = acc | beat_oh;
    assign beat_dup = |(acc & beat_oh);

    popcount_vec #(.VEC_W(VEC_W), .OUT_W(IDX_W + 1)) u_pop (
        .vec (merged),
        .cnt (merged_cnt)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = in_last ? HOLD : COLLECT;
            COLLECT: if (accept && in_last) state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            dup         <= 1'b0;
            out_vec     <= '0;
            out_cnt     <= '0;
            out_dup     <= 1'b0;
            out_valid   <= 1'b0;
            frames_done <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (in_last) begin
                    // Close the frame: publish the merged vector, clear for the next.
                    out_vec   <= merged;
                    out_cnt   <= merged_cnt;
                    out_dup   <= dup | beat_dup;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    dup       <= 1'b0;
                end else begin
                    acc <= merged;
                    dup <= dup | beat_dup;
                end
            end
            if (state == HOLD && out_ready) begin
                out_valid   <= 1'b0;
                frames_done <= frames_done + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prio_dec_collect.sv
// Directed table of frames plus hand-written reset / hold / wrap / bubble sequences.
module tb_prio_dec_collect;
    import prio_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_idx;
    logic       in_valid, in_last, in_ready;
    logic [7:0] out_vec;
    logic [3:0] out_cnt;
    logic       out_dup, out_valid, out_ready;
    logic [7:0] frames_done;

    int checks   = 0;
    int failures = 0;
    int exp_fd   = 0;

    prio_dec_collect #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_idx(in_idx), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_vec(out_vec),
        .out_cnt(out_cnt), .out_dup(out_dup), .out_valid(out_valid),
        .out_ready(out_ready), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [23:0] ix;    // beat k at ix[3k+2:3k]
        logic [7:0]  vec;
        logic [3:0]  cnt;
        logic        dup;
        int          hold;
    } frame_t;

    frame_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] hi_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [2:0] idx, input logic last, input int bub);
        int guard;
        for (int b = 0; b < bub; b++) begin
            in_valid = 1'b0;
            in_idx   = 3'($urandom);
            in_last  = 1'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_idx   = idx;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_fd    = (exp_fd + 1) % 256;
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_ready", 32'(in_ready), 32'd1);
        chk("rel_fd", 32'(frames_done), 32'(exp_fd));
    endtask

    task automatic check_out(input string nm, input logic [7:0] v, input logic [3:0] c, input logic d);
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_vec"}, 32'(out_vec), 32'(v));
        chk({nm, "_cnt"}, 32'(out_cnt), 32'(c));
        chk({nm, "_dup"}, 32'(out_dup), 32'(d));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst    = 1'b0;
        exp_fd = 0;
    endtask

    initial begin
        logic [7:0] mv;
        logic       md;
        logic [2:0] ri;
        int         n;

        tbl[0] = '{1, {21'd0, 3'd5},                                  8'b0010_0000, 4'd1, 1'b0, 0};
        tbl[1] = '{3, {15'd0, 3'd7, 3'd3, 3'd0},                      8'b1000_1001, 4'd3, 1'b0, 4};
        tbl[2] = '{3, {15'd0, 3'd6, 3'd2, 3'd2},                      8'b0100_0100, 4'd2, 1'b1, 1};
        tbl[3] = '{1, {21'd0, 3'd1},                                  8'b0000_0010, 4'd1, 1'b0, 0};
        tbl[4] = '{8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8'hFF,      4'd8, 1'b0, 2};
        tbl[5] = '{4, {12'd0, 3'd3, 3'd3, 3'd5, 3'd3},                8'b0010_1000, 4'd2, 1'b1, 0};
        tbl[6] = '{2, {18'd0, 3'd0, 3'd7},                            8'b1000_0001, 4'd2, 1'b0, 3};

        in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
        do_reset();
        chk("rst_vec", 32'(out_vec), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_dup", 32'(out_dup), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fd", 32'(frames_done), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Table-driven frames, each stalled for `hold` cycles before release.
        for (int t = 0; t < 7; t++) begin
            for (int b = 0; b < tbl[t].n; b++)
                send_beat(tbl[t].ix[3*b +: 3], b == tbl[t].n - 1, 0);
            check_out($sformatf("tbl%0d", t), tbl[t].vec, tbl[t].cnt, tbl[t].dup);
            for (int h = 0; h < tbl[t].hold; h++) begin
                tick();
                chk($sformatf("tbl%0d_hold_vec", t), 32'(out_vec), 32'(tbl[t].vec));
                chk($sformatf("tbl%0d_hold_cnt", t), 32'(out_cnt), 32'(tbl[t].cnt));
                chk($sformatf("tbl%0d_hold_rdy", t), 32'(in_ready), 32'd0);
            end
            if (t == 4) chk("enc_of_vec", 32'(hi_idx(out_vec)), 32'd7);
            release_out();
        end

        // A beat offered during HOLD must wait, then become the next frame.
        send_beat(3'd6, 1'b1, 0);
        in_valid = 1'b1; in_idx = 3'd3; in_last = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk("blk_vec", 32'(out_vec), 32'h40);
            chk("blk_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_fd++;
        chk("blk_rel_valid", 32'(out_valid), 32'd0);
        chk("blk_rel_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("blk_next", 8'b0000_1000, 4'd1, 1'b0);
        release_out();

        // Mid-frame reset discards the partial accumulator.
        send_beat(3'd4, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        exp_fd = 0;
        chk("mrst_fd", 32'(frames_done), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_rdy", 32'(in_ready), 32'd1);
        send_beat(3'd1, 1'b1, 0);
        check_out("mrst", 8'b0000_0010, 4'd1, 1'b0);
        release_out();

        // 256 single-beat frames with the consumer always ready: counter wraps.
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            send_beat(3'(f), 1'b1, 0);
            if (f == 255) chk("wrap_pre", 32'(frames_done), 32'd255);
        end
        tick();
        out_ready = 1'b0;
        chk("wrap_fd", 32'(frames_done), 32'd0);
        exp_fd = 0;

        // Random frames with input bubbles and output stalls against a bench model.
        for (int f = 0; f < 20; f++) begin
            n  = $urandom_range(1, 5);
            mv = '0;
            md = 1'b0;
            for (int b = 0; b < n; b++) begin
                ri = 3'($urandom);
                md = md | mv[ri];
                mv[ri] = 1'b1;
                send_beat(ri, b == n - 1, $urandom_range(0, 2));
            end
            check_out($sformatf("rnd%0d", f), mv, 4'($countones(mv)), md);
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) tick();
            chk($sformatf("rnd%0d_stable", f), 32'(out_vec), 32'(mv));
            release_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/prio_dec_collect.md
Name: prio_dec_collect

Overview:
- Inverse of the 8-to-3 priority encoder: rebuilds an 8-bit request vector from a stream of 3-bit indices.
- Input side: a valid/ready stream of index beats; in_last closes a frame.
- Output side: registered one-hot-OR vector with valid/ready handshake, plus a set-bit count and a duplicate-index flag.
- Sits downstream of index producers; its out_vec feeds the priority encoder again, so encoder(out_vec) equals the highest index in the frame.

Parameters:
- IDX_W, 3, width of the index input.
- VEC_W, 2**IDX_W (8), width of the rebuilt vector; derived, not overridden.
- CNT_W, 8, width of the wrapping frames_done counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_idx  input  IDX_W  index to set in the vector.
- in_valid  input  1  in_idx/in_last are valid.
- in_last  input  1  current beat closes the frame.
- in_ready  output  1  block can accept a beat.
- out_vec  output  VEC_W  rebuilt vector.
- out_cnt  output  IDX_W+1  number of ones in out_vec (0..8).
- out_dup  output  1  an index was repeated within the frame.
- out_valid  output  1  out_vec/out_cnt/out_dup are valid.
- out_ready  input  1  consumer takes the output.
- frames_done  output  CNT_W  frames delivered (handshake completed), wraps.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - state IDLE; internal accumulator acc=0; dup flag=0.
  - out_vec=0, out_cnt=0, out_dup=0, out_valid=0, frames_done=0.
  - in_ready=1 from the first cycle after reset.
- Accept rule: a beat is accepted when in_valid && in_ready at a rising edge. in_ready = (state != HOLD), purely registered-state driven, with no combinational path from out_ready.
- States:
  - IDLE: acc empty. Accepted beat without last -> COLLECT. Accepted beat with last -> HOLD.
  - COLLECT: acc non-empty. Accepted beat with last -> HOLD; otherwise stay.
  - HOLD: out_valid=1, in_ready=0. If out_ready -> IDLE next cycle.
- Accept update: acc <= acc | (1 << in_idx). If acc[in_idx] is already 1, the dup flag is set (sticky for the frame).
- Frame close (in_last accepted): at that same edge:
  - out_vec <= acc | onehot(in_idx); out_cnt <= popcount of that value; out_dup <= dup flag OR the current-beat duplicate.
  - out_valid <= 1; acc <= 0; dup flag <= 0.
  - Latency: out_valid is high in the cycle after the last beat.
- HOLD stability: out_vec/out_cnt/out_dup stay stable while out_valid=1 and out_ready=0.
- HOLD release (out_ready=1): out_valid <= 0 and frames_done <= frames_done+1, wrapping 255 -> 0. out_vec keeps its last value; don't-care once out_valid=0.
- Single-beat frame (in_last on the first beat): out_vec is the pure one-hot decode of in_idx, out_cnt=1.
- in_valid=0: no state change. in_idx/in_last are ignored when not accepted.
- Beats presented in HOLD are not accepted; the producer must hold them (standard valid/ready: in_valid stays asserted, data stable).
- No empty frame exists: every frame has at least one beat.
- Minimum back-to-back throughput: one frame per (beats+1) cycles. There is no bubble-free overlap between HOLD and the next frame.
- Mid-frame reset: acc, dup flag and any pending output are discarded; all outputs return to reset values on the next edge.
- Counter widths: out_cnt is IDX_W+1 bits so 8 fits; popcount is combinational over VEC_W bits, then registered.

Decomposition:
- Shared package prio_pkg:
  - constants IDX_W=3, VEC_W=8;
  - state enum {IDLE, COLLECT, HOLD};
  - function onehot(idx).
- The same package is reused by the priority encoder and its bench.
- One sub-module, popcount_vec (VEC_W in, IDX_W+1 out, combinational), instantiated once.
- FSM, accumulator and output register stay in prio_dec_collect.

Test Plan:
- Reset, then a single beat in_idx=5, in_last=1, out_ready=1 -> next cycle out_vec=8'b0010_0000, out_cnt=1, out_dup=0, out_valid=1; frames_done=1 after the handshake.
- Frame idx 0, 3, 7 (last on 7), out_ready=0 for 4 cycles -> out_vec=8'b1000_1001, out_cnt=3 held stable; in_ready=0 during HOLD; out_ready=1 -> out_valid falls next cycle, in_ready=1.
- Frame idx 2, 2, 6(last) -> out_vec=8'b0100_0100, out_cnt=2, out_dup=1. The next frame with idx 1(last) gives out_dup=0, proving the flag clears per frame.
- Frame of all 8 indices 0..7 -> out_vec=8'hFF, out_cnt=8. Encoder check: priority_enc(out_vec)=7.
- Beat idx 4 accepted, then rst=1 for one cycle, then idx 1(last) -> out_vec=8'b0000_0010 (bit 4 discarded), frames_done restarts from 0.
- 256 single-beat frames with out_ready tied 1 -> frames_done wraps to 0. in_valid toggling randomly yields no lost or duplicated beats; compare against a reference model built with the encoder's bench file format.
